custom_axi_ip_regs: RTL and testbench
=====================================

# custom_axi_ip_regs

AXI4-Lite slave register front-end that sits directly upstream of the `custom_axi_ip` compute core. It turns bus writes into the core's `ipreg_data` and one-cycle `enable` strobe. It returns the core's result word and `status_e` state to software. Sticky DONE/ERROR flags let software poll without catching transient states.

## Interface
- `DATA_WIDTH`, 32, AXI data width; only 32 is supported.
- `ADDR_WIDTH`, 4, AXI address width; must be ≥ 4.
- `clk_i`  in  1  single clock for all logic
- `rst_i`  in  1  reset, synchronous, active-high
- `s_axi_awaddr`  in  ADDR_WIDTH  write address
- `s_axi_awvalid` in 1, `s_axi_awready` out 1  AW handshake
- `s_axi_wdata`  in  32  write data
- `s_axi_wstrb`  in  4  byte strobes
- `s_axi_wvalid` in 1, `s_axi_wready` out 1  W handshake
- `s_axi_bresp`  out  2  write response: OKAY=0, SLVERR=2
- `s_axi_bvalid` out 1, `s_axi_bready` in 1  B handshake
- `s_axi_araddr`  in  ADDR_WIDTH  read address
- `s_axi_arvalid` in 1, `s_axi_arready` out 1  AR handshake
- `s_axi_rdata`  out  32  read data
- `s_axi_rresp`  out  2  read response
- `s_axi_rvalid` out 1, `s_axi_rready` in 1  R handshake
- `ipreg_data`  out  32  operand to core; equals the DATA_IN register
- `enable_out`  out  1  one-cycle start strobe to the core's `enable_in`
- `ipreg_data_in`  in  32  result from the core's `ipreg_data_out`
- `status_in`  in  2  core state as `status_e`: IDLE=0, BUSY=1, DONE=2, ERROR=3

## Operation
- **Register map** (decode `addr[3:2]`; `addr[1:0]` ignored):
  - 0x0 CTRL: W-only. bit0 START is self-clearing and reads 0.
  - 0x4 DATA_IN: RW, WSTRB honoured per byte.
  - 0x8 DATA_OUT: RO, reads `ipreg_data_in` live.
  - 0xC STATUS: bits[1:0] = `status_in` live. bit2 DONE_STICKY (W1C). bit3 ERR_STICKY (W1C). Other bits read 0.
- **Out-of-range addresses and writes to DATA_OUT** (any address bit ≥ 4 nonzero): write ignored, BRESP=SLVERR. Out-of-range reads return RDATA=0, RRESP=SLVERR. A write to STATUS is legal, is W1C only, and returns OKAY.
- **Write to CTRL with WSTRB[0]=1 and wdata[0]=1:**
  - If `status_in`==IDLE, `enable_out`=1 for exactly the next cycle.
  - Otherwise no strobe, ERR_STICKY set, BRESP still OKAY.
- **DONE_STICKY** is set on any cycle where `status_in`==DONE.
- **ERR_STICKY** is set on any cycle where `status_in`==ERROR, or on a rejected START.
- **Simultaneous hardware set and W1C clear** of the same bit: set wins.
- **Write channel:**
  - AW and W are accepted independently and in either order. Each is latched in its own holding register with a "got" flag.
  - `awready` = !aw_got && !bvalid. `wready` = !w_got && !bvalid.
  - The commit happens on the edge where the later of the two handshakes completes, or both together. On that edge the register updates, `bvalid` rises, and both flags clear.
  - `bvalid` holds, with `bresp` stable, until `bready`. No new AW/W is accepted while `bvalid`=1.
- **Read channel:**
  - `arready` = !rvalid.
  - On the AR handshake edge, `rdata`/`rresp` are registered as a snapshot and `rvalid` rises.
  - `rvalid` holds, with data stable, until `rready`.
  - Reads and writes are fully independent. A same-edge read of a register being written returns the pre-write value.
- **Reset:** `rst_i` high at a clock edge clears all state, including mid-transaction. Pending AW/W are dropped and B/R are aborted.

## Timing
- **Reset values:** `bvalid`=0, `bresp`=0, `rvalid`=0, `rdata`=0, `rresp`=0, `enable_out`=0, `ipreg_data`=0, DONE_STICKY=0, ERR_STICKY=0, holding flags=0.
- **Ready outputs:** `awready`/`wready`/`arready` are combinational from state, so they are 1 in reset state.
- **Write latency:** AW+W together at edge N → `bvalid`=1 and the register updated after edge N. Back-to-back writes are possible every 2 cycles when `bready` is held high.
- **Read latency:** AR at edge N → `rvalid`=1 after edge N. Throughput is 1 read per 2 cycles with `rready` held high.
- **START latency:** commit at edge N → `enable_out`=1 during cycle N+1 and 0 after edge N+1. `ipreg_data` already holds the new DATA_IN if it was written earlier.
- **Status/sticky latency:** `status_in` is sampled every edge. The sticky bit is visible to a read accepted one edge later.

## Test plan
- **Reset, then read all registers:** CTRL=0, DATA_IN=0, DATA_OUT equals `ipreg_data_in`, STATUS=0 with core IDLE; all RRESP=OKAY.
- **Write-order variants:** write DATA_IN=0x1234_5678 with AW-first, W-first, and simultaneous orders, then read back → 0x1234_5678.
- **Byte strobe:** WSTRB=0b0010 with data 0xAABB_CCDD over 0x1234_5678 → 0x1234_CC78.
- **START while IDLE:** write CTRL=1 → `enable_out` high exactly one cycle. Model the core: IDLE→BUSY→DONE with `ipreg_data_in`=0x1234_5679 → DATA_OUT=0x1234_5679, STATUS bit2=1. Write STATUS=0x4 → bit2 clears.
- **START while busy / error state:** START while `status_in`=BUSY → no strobe, STATUS bit3=1. Drive `status_in`=ERROR and W1C bit3 on the same edge → bit3 remains 1.
- **Address and backpressure:** read 0x8 with ADDR_WIDTH=5 and address 0x10 → RDATA=0, SLVERR. Write to 0x8 → SLVERR, DATA_OUT unchanged. Hold `bready`/`rready` low 5 cycles → `bvalid`/`rvalid` and data stable, `awready`/`wready`/`arready`=0. Assert `rst_i` mid-hold → all valids 0 next cycle.

Source files
------------

// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register front-end for the custom_axi_ip compute core.
// Holds the DATA_IN operand, issues the one-cycle start strobe, and exposes the
// core result and state along with sticky DONE/ERROR flags.
module custom_axi_ip_regs #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready,
   output logic [DATA_WIDTH-1:0]   ipreg_data,
   output logic                    enable_out,
   input  logic [DATA_WIDTH-1:0]   ipreg_data_in,
   input  logic [1:0]              status_in
);

   localparam int unsigned StrbWidth = DATA_WIDTH / 8;
   localparam logic [1:0] RespOkay   = 2'd0;
   localparam logic [1:0] RespSlvErr = 2'd2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBusy  = 2'd1,
      StDone  = 2'd2,
      StError = 2'd3
   } status_e;

   logic                  aw_got_q, w_got_q;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [StrbWidth-1:0]  w_strb_q;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic                  done_q, done_d, err_q, err_d;
   logic                  enable_q;
   logic                  bvalid_q, rvalid_q;
   logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [StrbWidth-1:0]  wr_strb;
   logic                  start_ok, start_rej, done_clr, err_clr;
   logic                  unused_addr_lsbs;

   // Any address bit above the 16-byte window makes the access out of range.
   function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
      return (a >> 4) != '0;
   endfunction

   assign s_axi_awready = !aw_got_q && !bvalid_q;
   assign s_axi_wready  = !w_got_q && !bvalid_q;
   assign s_axi_arready = !rvalid_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign ipreg_data    = data_in_q;
   assign enable_out    = enable_q;

   assign unused_addr_lsbs = ^{wr_addr[1:0], s_axi_araddr[1:0]};

   // Write decode: merge held and live AW/W, commit once both halves are present.
   always_comb begin
      aw_hs     = s_axi_awvalid && s_axi_awready;
      w_hs      = s_axi_wvalid && s_axi_wready;
      commit    = (aw_hs || aw_got_q) && (w_hs || w_got_q);
      wr_addr   = aw_got_q ? aw_addr_q : s_axi_awaddr;
      wr_data   = w_got_q ? w_data_q : s_axi_wdata;
      wr_strb   = w_got_q ? w_strb_q : s_axi_wstrb;
      data_in_d = data_in_q;
      bresp_d   = RespOkay;
      start_ok  = 1'b0;
      start_rej = 1'b0;
      done_clr  = 1'b0;
      err_clr   = 1'b0;
      if (commit) begin
         if (addr_oor(wr_addr)) begin
            bresp_d = RespSlvErr;
         end else begin
            unique case (wr_addr[3:2])
               2'd0: begin
                  if (wr_strb[0] && wr_data[0]) begin
                     if (status_in == StIdle) start_ok = 1'b1;
                     else                     start_rej = 1'b1;
                  end
               end
               2'd1: begin
                  for (int b = 0; b < StrbWidth; b++) begin
                     if (wr_strb[b]) data_in_d[8*b +: 8] = wr_data[8*b +: 8];
                  end
               end
               2'd2: bresp_d = RespSlvErr;
               default: begin
                  if (wr_strb[0]) begin
                     done_clr = wr_data[2];
                     err_clr  = wr_data[3];
                  end
               end
            endcase
         end
      end
      // Hardware set beats a same-cycle W1C clear.
      done_d = (done_q && !done_clr) || (status_in == StDone);
      err_d  = (err_q && !err_clr) || (status_in == StError) || start_rej;
   end

   // Read decode: snapshot of pre-write register state.
   always_comb begin
      ar_hs   = s_axi_arvalid && !rvalid_q;
      rdata_d = '0;
      rresp_d = RespOkay;
      if (addr_oor(s_axi_araddr)) begin
         rresp_d = RespSlvErr;
      end else begin
         unique case (s_axi_araddr[3:2])
            2'd0:    rdata_d = '0;
            2'd1:    rdata_d = data_in_q;
            2'd2:    rdata_d = ipreg_data_in;
            default: rdata_d = {{(DATA_WIDTH-4){1'b0}}, err_q, done_q, status_in};
         endcase
      end
   end

   // Channel state, registers and sticky flags.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_got_q  <= 1'b0;
         w_got_q   <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         data_in_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         enable_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RespOkay;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RespOkay;
      end else begin
         if (aw_hs) aw_addr_q <= s_axi_awaddr;
         if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
         aw_got_q  <= !commit && (aw_got_q || aw_hs);
         w_got_q   <= !commit && (w_got_q || w_hs);
         data_in_q <= data_in_d;
         done_q    <= done_d;
         err_q     <= err_d;
         enable_q  <= start_ok;
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= bresp_d;
         end else if (s_axi_bready) begin
            bvalid_q <= 1'b0;
         end
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
         end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// Self-checking bench for custom_axi_ip_regs: directed scenarios plus a
// randomized phase checked against a register-map reference model.
module tb_custom_axi_ip_regs;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [4:0]  s_axi_awaddr = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [4:0]  s_axi_araddr = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic [31:0] ipreg_data;
   logic        enable_out;
   logic [31:0] ipreg_data_in = 32'hCAFE_0001;
   logic [1:0]  status_in = 2'd0;

   int n_checks = 0;
   int n_errors = 0;
   int en_cnt   = 0;

   // Reference model state
   logic [31:0] m_data = '0;
   logic        m_done = 1'b0;
   logic        m_err  = 1'b0;
   int          m_starts = 0;

   custom_axi_ip_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .ipreg_data    (ipreg_data),
      .enable_out    (enable_out),
      .ipreg_data_in (ipreg_data_in),
      .status_in     (status_in)
   );

   always #5 clk_i = ~clk_i;

   // Each cycle the strobe is high adds one, so a stretched pulse is visible.
   always @(negedge clk_i) if (enable_out) en_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] model_read(input logic [4:0] a);
      if (a[4]) return {2'd2, 32'd0};
      case (a[3:2])
         2'd0:    return {2'd0, 32'd0};
         2'd1:    return {2'd0, m_data};
         2'd2:    return {2'd0, ipreg_data_in};
         default: return {2'd0, 28'd0, m_err, m_done, status_in};
      endcase
   endfunction

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp);
      resp = 2'd0;
      if (a[4] || a[3:2] == 2'd2) begin
         resp = 2'd2;
      end else if (a[3:2] == 2'd0) begin
         if (s[0] && d[0]) begin
            if (status_in == 2'd0) m_starts++;
            else                   m_err = 1'b1;
         end
      end else if (a[3:2] == 2'd1) begin
         for (int b = 0; b < 4; b++) if (s[b]) m_data[8*b +: 8] = d[8*b +: 8];
      end else if (s[0]) begin
         if (d[2] && status_in != 2'd2) m_done = 1'b0;
         if (d[3] && status_in != 2'd3) m_err = 1'b0;
      end
   endtask

   task automatic set_core(input logic [1:0] st, input logic [31:0] res);
      status_in     = st;
      ipreg_data_in = res;
      @(posedge clk_i); #1;
      if (st == 2'd2) m_done = 1'b1;
      if (st == 2'd3) m_err = 1'b1;
   endtask

   // order: 0 = AW first, 1 = W first, 2 = both together
   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int order);
      logic [1:0] exp_resp;
      int         starts_before;
      int         n;
      starts_before = m_starts;
      model_write(a, d, s, exp_resp);
      if (order != 1) begin s_axi_awaddr = a; s_axi_awvalid = 1'b1; end
      if (order != 0) begin s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1; end
      if (order != 2) begin
         @(posedge clk_i); #1;
         if (order == 0) begin
            check_eq("awready_held", s_axi_awready, 1'b0);
            s_axi_awvalid = 1'b0;
            s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
         end else begin
            check_eq("wready_held", s_axi_wready, 1'b0);
            s_axi_wvalid = 1'b0;
            s_axi_awaddr = a; s_axi_awvalid = 1'b1;
         end
      end
      @(posedge clk_i); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      check_eq("enable_out", enable_out, m_starts != starts_before);
      n = 0;
      while (!s_axi_bvalid && n < 10) begin @(posedge clk_i); #1; n++; end
      check_eq("b_latency", n, 0);
      check_eq("bresp", s_axi_bresp, exp_resp);
      s_axi_bready = 1'b1;
      @(posedge clk_i); #1;
      s_axi_bready = 1'b0;
      check_eq("bvalid_clear", s_axi_bvalid, 1'b0);
      check_eq("ipreg_data", ipreg_data, m_data);
      check_eq("enable_count", en_cnt, m_starts);
   endtask

   task automatic do_read(input logic [4:0] a);
      logic [33:0] exp;
      int          n;
      exp = model_read(a);
      s_axi_araddr  = a;
      s_axi_arvalid = 1'b1;
      @(posedge clk_i); #1;
      s_axi_arvalid = 1'b0;
      n = 0;
      while (!s_axi_rvalid && n < 10) begin @(posedge clk_i); #1; n++; end
      check_eq("r_latency", n, 0);
      check_eq($sformatf("rdata@%0h", a), s_axi_rdata, exp[31:0]);
      check_eq($sformatf("rresp@%0h", a), s_axi_rresp, exp[33:32]);
      s_axi_rready = 1'b1;
      @(posedge clk_i); #1;
      s_axi_rready = 1'b0;
      check_eq("rvalid_clear", s_axi_rvalid, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] snap;
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      check_eq("rst_awready", s_axi_awready, 1'b1);
      check_eq("rst_wready", s_axi_wready, 1'b1);
      check_eq("rst_arready", s_axi_arready, 1'b1);
      check_eq("rst_bvalid", s_axi_bvalid, 1'b0);
      check_eq("rst_bresp", s_axi_bresp, 2'd0);
      check_eq("rst_rvalid", s_axi_rvalid, 1'b0);
      check_eq("rst_rdata", s_axi_rdata, 32'd0);
      check_eq("rst_enable", enable_out, 1'b0);
      check_eq("rst_ipreg_data", ipreg_data, 32'd0);
      for (int i = 0; i < 4; i++) do_read(5'(i * 4));

      // Write-order variants
      for (int o = 0; o < 3; o++) begin
         do_write(5'h04, 32'h0000_0000, 4'hF, 2);
         do_write(5'h04, 32'h1234_5678, 4'hF, o);
         do_read(5'h04);
      end

      // Byte strobe
      do_write(5'h04, 32'hAABB_CCDD, 4'b0010, 2);
      check_eq("strobe_merge", ipreg_data, 32'h1234_CC78);
      do_read(5'h04);

      // START while idle, then core runs to DONE
      do_write(5'h00, 32'h1, 4'hF, 2);
      set_core(2'd1, 32'h0);
      set_core(2'd2, 32'h1234_5679);
      do_read(5'h08);
      do_read(5'h0C);
      set_core(2'd0, 32'h1234_5679);
      do_write(5'h0C, 32'h4, 4'hF, 2);
      do_read(5'h0C);

      // START while busy, then ERROR set racing a W1C clear
      set_core(2'd1, 32'h0);
      do_write(5'h00, 32'h1, 4'hF, 0);
      do_read(5'h0C);
      set_core(2'd3, 32'h0);
      do_write(5'h0C, 32'h8, 4'hF, 1);
      do_read(5'h0C);
      set_core(2'd0, 32'h0);
      do_write(5'h0C, 32'hC, 4'hF, 2);
      do_read(5'h0C);

      // Out-of-range and read-only targets
      do_read(5'h10);
      do_write(5'h08, 32'hDEAD_BEEF, 4'hF, 2);
      do_read(5'h08);
      do_write(5'h14, 32'hDEAD_BEEF, 4'hF, 0);
      do_read(5'h04);

      // Randomized traffic
      for (int i = 0; i < 80; i++) begin
         logic [31:0] rnd_d;
         logic [3:0]  rnd_s;
         rnd_d = $urandom;
         rnd_s = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 5))
            0: do_write(5'h04, rnd_d, rnd_s, $urandom_range(0, 2));
            1: do_write(5'h00, rnd_d, rnd_s, $urandom_range(0, 2));
            2: do_write(5'h0C, rnd_d, rnd_s, $urandom_range(0, 2));
            3: do_write(5'($urandom_range(0, 31)), rnd_d, rnd_s, $urandom_range(0, 2));
            4: set_core(2'($urandom_range(0, 3)), $urandom);
            default: do_read(5'($urandom_range(0, 31)));
         endcase
      end

      // Backpressure: same-edge read of DATA_IN during a write, both responses stalled
      set_core(2'd0, 32'h0);
      do_write(5'h04, 32'h0BAD_F00D, 4'hF, 2);
      s_axi_araddr  = 5'h04; s_axi_arvalid = 1'b1;
      s_axi_awaddr  = 5'h04; s_axi_awvalid = 1'b1;
      s_axi_wdata   = 32'h5555_AAAA; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      @(posedge clk_i); #1;
      s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      snap = s_axi_rdata;
      check_eq("same_edge_rdata", snap, 32'h0BAD_F00D);
      repeat (5) begin
         @(posedge clk_i); #1;
         check_eq("hold_bvalid", s_axi_bvalid, 1'b1);
         check_eq("hold_bresp", s_axi_bresp, 2'd0);
         check_eq("hold_rvalid", s_axi_rvalid, 1'b1);
         check_eq("hold_rdata", s_axi_rdata, snap);
         check_eq("hold_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      end
      check_eq("hold_ipreg_data", ipreg_data, 32'h5555_AAAA);

      // Reset mid-hold aborts both responses
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      m_data = '0; m_done = 1'b0; m_err = 1'b0;
      check_eq("abort_bvalid", s_axi_bvalid, 1'b0);
      check_eq("abort_rvalid", s_axi_rvalid, 1'b0);
      check_eq("abort_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      do_read(5'h04);
      do_read(5'h0C);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
